// File: rtl/pwm_ramp_pkg.sv
// Shared types and helpers for the pwm_ramp soft-start sequencer.
// State encodings and the saturating step rule used by both ramp directions.
package pwm_ramp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    // One step from cur toward goal, clamped at goal. Wide signed
    // arithmetic means neither direction can wrap.
    function automatic int step_limit(input int cur, input int goal, input int step);
        if (goal > cur) begin
            return (cur + step > goal) ? goal : cur + step;
        end else if (goal < cur) begin
            return (cur - step < goal) ? goal : cur - step;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/pwm_ramp_step.sv
// Combinational saturating step: moves cur one STEP toward goal without overshoot.
// Shared by the ramp-up/retarget path and the soft-stop ramp-down path.
module pwm_ramp_step
    import pwm_ramp_pkg::*;
#(
    parameter int B_WIDTH = 8,
    parameter int STEP    = 1
) (
    input  logic [B_WIDTH-1:0] cur,
    input  logic [B_WIDTH-1:0] goal,
    output logic [B_WIDTH-1:0] step_val
);

    always_comb begin
        step_val = B_WIDTH'(step_limit(int'(cur), int'(goal), STEP));
    end

endmodule

// File: rtl/pwm_ramp.sv
// Soft-start duty sequencer driving a pwm's sel_width/count_en/s_rst.
// Optional soft stop (ramp back to 0 before halting) under PWM_RAMP_SOFT_STOP_EN.
module pwm_ramp
    import pwm_ramp_pkg::*;
#(
    parameter int B_WIDTH = 8,
    parameter int B_DWELL = 4,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [B_WIDTH-1:0] target,
    input  logic [B_DWELL-1:0] dwell,
    input  logic               cyc,
    output logic [B_WIDTH-1:0] sel_width,
    output logic               count_en,
    output logic               s_rst,
    output logic               busy,
    output logic               at_target
);

`ifdef PWM_RAMP_SOFT_STOP_EN
    localparam state_t STOP_STATE = ST_DOWN;
`else
    localparam state_t STOP_STATE = ST_IDLE;
`endif

    state_t               state;
    state_t               state_nxt;
    logic                 cyc_d;
    logic                 per_q;
    logic [B_DWELL-1:0]   dwell_cnt;
    logic [B_WIDTH-1:0]   goal;
    logic [B_WIDTH-1:0]   step_val;
    logic                 dwell_hit;
    logic                 stepping;
    logic                 count_en_nxt;
    logic                 s_rst_nxt;
    logic                 busy_nxt;
    logic                 at_target_nxt;

    // Period strobe is delayed one clk so sel_width moves 2 clk after cyc
    // rises, still inside the cyc window where pwm latches sel_width.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_d <= 1'b1;
            per_q <= 1'b0;
        end else begin
            cyc_d <= cyc;
            per_q <= cyc & ~cyc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (stop) begin
                    state_nxt = STOP_STATE;
                end else if (sel_width == target) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_nxt = STOP_STATE;
                end else if (sel_width != target) begin
                    state_nxt = ST_RAMP;
                end
            end
`ifdef PWM_RAMP_SOFT_STOP_EN
            ST_DOWN: begin
                if (sel_width == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign goal      = (state == ST_DOWN) ? '0 : target;
    // A shrunken dwell below the running count counts as a match.
    assign dwell_hit = (dwell_cnt >= dwell);
    assign stepping  = per_q && (state_nxt == state)
                       && ((state == ST_RAMP) || (state == ST_DOWN));

    pwm_ramp_step #(
        .B_WIDTH (B_WIDTH),
        .STEP    (STEP)
    ) u_step (
        .cur      (sel_width),
        .goal     (goal),
        .step_val (step_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_width <= '0;
            dwell_cnt <= '0;
        end else if (state_nxt == ST_IDLE) begin
            sel_width <= '0;
            dwell_cnt <= '0;
        end else if (state_nxt != state) begin
            dwell_cnt <= '0;
        end else if (stepping) begin
            if (dwell_hit) begin
                dwell_cnt <= '0;
                sel_width <= step_val;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    // Control outputs are decoded from the next state and registered,
    // so they line up with the state register on the same edge.
    always_comb begin
        count_en_nxt  = (state_nxt != ST_IDLE);
        s_rst_nxt     = (state_nxt == ST_IDLE);
        busy_nxt      = (state_nxt != ST_IDLE);
        at_target_nxt = (state_nxt == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_en  <= 1'b0;
            s_rst     <= 1'b1;
            busy      <= 1'b0;
            at_target <= 1'b0;
        end else begin
            count_en  <= count_en_nxt;
            s_rst     <= s_rst_nxt;
            busy      <= busy_nxt;
            at_target <= at_target_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_ramp.sv
// Bench for pwm_ramp: three instances (STEP 16/48/32) fed identical stimulus,
// each checked per PWM period against a period-level model of the ramp rules.
`timescale 1ns/1ps
module tb_pwm_ramp;

    localparam int N  = 3;
    localparam int BW = 8;
    localparam int BD = 4;

`ifdef PWM_RAMP_SOFT_STOP_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    typedef enum int {M_IDLE, M_RAMP, M_HOLD, M_DOWN} mode_t;
    typedef enum int {OP_PER, OP_START, OP_STOP, OP_BOTH, OP_TGT, OP_DWELL} op_k;
    typedef struct {
        op_k k;
        int  v;
    } op_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          stop   = 1'b0;
    logic          cyc    = 1'b0;
    logic [BW-1:0] target = '0;
    logic [BD-1:0] dwell  = '0;

    logic [BW-1:0] sel_w [N];
    logic          ce    [N];
    logic          sr    [N];
    logic          bz    [N];
    logic          at    [N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            localparam int ST = (g == 0) ? 16 : (g == 1) ? 48 : 32;
            pwm_ramp #(
                .B_WIDTH (BW),
                .B_DWELL (BD),
                .STEP    (ST)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (start),
                .stop      (stop),
                .target    (target),
                .dwell     (dwell),
                .cyc       (cyc),
                .sel_width (sel_w[g]),
                .count_en  (ce[g]),
                .s_rst     (sr[g]),
                .busy      (bz[g]),
                .at_target (at[g])
            );
        end
    endgenerate

    // ---------------- reference model (one update per PWM period) -------------
    int    m_step [N] = '{16, 48, 32};
    mode_t m_mode [N];
    int    m_sel  [N];
    int    m_dcnt [N];

    function automatic int toward(input int cur, input int goal, input int step);
        int r;
        if (goal > cur)      r = (cur + step < goal) ? cur + step : goal;
        else if (goal < cur) r = (cur - step > goal) ? cur - step : goal;
        else                 r = cur;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = M_IDLE;
            m_sel[i]  = 0;
            m_dcnt[i] = 0;
        end
    endtask

    task automatic model_settle();
        for (int i = 0; i < N; i++) begin
            for (int r = 0; r < 3; r++) begin
                if (m_mode[i] == M_RAMP && m_sel[i] == int'(target)) begin
                    m_mode[i] = M_HOLD;
                    m_dcnt[i] = 0;
                end else if (m_mode[i] == M_HOLD && m_sel[i] != int'(target)) begin
                    m_mode[i] = M_RAMP;
                    m_dcnt[i] = 0;
                end else if (m_mode[i] == M_DOWN && m_sel[i] == 0) begin
                    m_mode[i] = M_IDLE;
                end
            end
        end
    endtask

    task automatic model_period();
        for (int i = 0; i < N; i++) begin
            if (m_mode[i] == M_RAMP || m_mode[i] == M_DOWN) begin
                if (m_dcnt[i] >= int'(dwell)) begin
                    m_sel[i]  = toward(m_sel[i], (m_mode[i] == M_DOWN) ? 0 : int'(target), m_step[i]);
                    m_dcnt[i] = 0;
                end else begin
                    m_dcnt[i]++;
                end
            end
        end
        model_settle();
    endtask

    task automatic model_ctrl(input bit st, input bit sp);
        for (int i = 0; i < N; i++) begin
            if (sp) begin
                if (m_mode[i] == M_RAMP || m_mode[i] == M_HOLD) begin
                    if (SOFT) begin
                        m_mode[i] = M_DOWN;
                        m_dcnt[i] = 0;
                    end else begin
                        m_mode[i] = M_IDLE;
                        m_sel[i]  = 0;
                        m_dcnt[i] = 0;
                    end
                end
            end else if (st && m_mode[i] == M_IDLE) begin
                m_mode[i] = M_RAMP;
                m_dcnt[i] = 0;
            end
        end
        model_settle();
    endtask

    function automatic logic [11:0] obs(input int i);
        return {sel_w[i], ce[i], sr[i], bz[i], at[i]};
    endfunction

    function automatic logic [11:0] expw(input int i);
        return {8'(m_sel[i]), m_mode[i] != M_IDLE, m_mode[i] == M_IDLE,
                m_mode[i] != M_IDLE, m_mode[i] == M_HOLD};
    endfunction

    // ---------------- stimulus (entered and left on a falling edge) -----------
    task automatic do_period();
        cyc = 1'b1;
        repeat (2) @(negedge clk);
        cyc = 1'b0;
        repeat (6) @(negedge clk);
        model_period();
    endtask

    task automatic do_ctrl(input bit st, input bit sp);
        start = st;
        stop  = sp;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        model_ctrl(st, sp);
    endtask

    task automatic apply_op(input op_t o);
        case (o.k)
            OP_PER:   do_period();
            OP_START: do_ctrl(1'b1, 1'b0);
            OP_STOP:  do_ctrl(1'b0, 1'b1);
            OP_BOTH:  do_ctrl(1'b1, 1'b1);
            OP_TGT: begin
                target = BW'(o.v);
                repeat (2) @(negedge clk);
                model_settle();
            end
            OP_DWELL: begin
                dwell = BD'(o.v);
                @(negedge clk);
            end
            default: @(negedge clk);
        endcase
    endtask

    task automatic hard_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        target = '0;
        dwell  = '0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic add_periods(inout op_t q[$], input int n);
        for (int k = 0; k < n; k++) q.push_back('{OP_PER, 0});
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs(i) !== expw(i)) begin
                n_err++;
                $display("FAIL reset dut%0d: got %h want %h", i, obs(i), expw(i));
            end
        end
    endtask

    task automatic test_ramp_up();
        op_t q[$];
        logic [7:0] exp16 [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        int pi = 0;
        hard_reset();
        q.push_back('{OP_DWELL, 0});
        q.push_back('{OP_TGT, 'h40});
        q.push_back('{OP_START, 0});
        add_periods(q, 6);
        foreach (q[j]) begin
            apply_op(q[j]);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs(i) !== expw(i)) begin
                    n_err++;
                    $display("FAIL ramp_up op%0d dut%0d: got %h want %h", j, i, obs(i), expw(i));
                end
            end
            if (q[j].k == OP_PER) begin
                pi++;
                if (pi <= 4) begin
                    n_cmp++;
                    if (sel_w[0] !== exp16[pi-1]) begin
                        n_err++;
                        $display("FAIL ramp_up_seq p%0d: got %h want %h", pi, sel_w[0], exp16[pi-1]);
                    end
                end
            end
        end
        n_cmp++;
        if (at[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ramp_up_at_target: got %b want 1", at[0]);
        end
    endtask

    task automatic test_saturate();
        op_t q[$];
        logic [7:0] exp48 [2] = '{8'h30, 8'h50};
        int pi = 0;
        hard_reset();
        q.push_back('{OP_TGT, 'h50});
        q.push_back('{OP_START, 0});
        add_periods(q, 6);
        q.push_back('{OP_TGT, 'hFF});
        add_periods(q, 12);
        foreach (q[j]) begin
            apply_op(q[j]);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs(i) !== expw(i)) begin
                    n_err++;
                    $display("FAIL saturate op%0d dut%0d: got %h want %h", j, i, obs(i), expw(i));
                end
            end
            if (q[j].k == OP_PER && j < 8) begin
                pi++;
                if (pi <= 2) begin
                    n_cmp++;
                    if (sel_w[1] !== exp48[pi-1]) begin
                        n_err++;
                        $display("FAIL saturate_seq p%0d: got %h want %h", pi, sel_w[1], exp48[pi-1]);
                    end
                end
            end
        end
        n_cmp++;
        if (sel_w[2] !== 8'hFF) begin
            n_err++;
            $display("FAIL no_wrap_top: got %h want ff", sel_w[2]);
        end
    endtask

    task automatic test_dwell();
        op_t q[$];
        hard_reset();
        q.push_back('{OP_DWELL, 3});
        q.push_back('{OP_TGT, 'h80});
        q.push_back('{OP_START, 0});
        add_periods(q, 10);
        q.push_back('{OP_DWELL, 0});
        add_periods(q, 6);
        foreach (q[j]) begin
            apply_op(q[j]);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs(i) !== expw(i)) begin
                    n_err++;
                    $display("FAIL dwell op%0d dut%0d: got %h want %h", j, i, obs(i), expw(i));
                end
            end
        end
    endtask

    task automatic test_retarget();
        op_t q[$];
        hard_reset();
        q.push_back('{OP_TGT, 'h40});
        q.push_back('{OP_START, 0});
        add_periods(q, 5);
        q.push_back('{OP_TGT, 'h20});
        add_periods(q, 4);
        foreach (q[j]) begin
            apply_op(q[j]);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs(i) !== expw(i)) begin
                    n_err++;
                    $display("FAIL retarget op%0d dut%0d: got %h want %h", j, i, obs(i), expw(i));
                end
            end
        end
    endtask

    task automatic test_stop();
        op_t q[$];
        hard_reset();
        q.push_back('{OP_TGT, 'h40});
        q.push_back('{OP_START, 0});
        add_periods(q, 5);
        q.push_back('{OP_STOP, 0});
        q.push_back('{OP_START, 0});
        add_periods(q, 6);
        q.push_back('{OP_STOP, 0});
        add_periods(q, 2);
        q.push_back('{OP_BOTH, 0});
        add_periods(q, 2);
        foreach (q[j]) begin
            apply_op(q[j]);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs(i) !== expw(i)) begin
                    n_err++;
                    $display("FAIL stop op%0d dut%0d: got %h want %h", j, i, obs(i), expw(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        op_t q[$];
        hard_reset();
        q.push_back('{OP_TGT, 'h80});
        q.push_back('{OP_START, 0});
        add_periods(q, 2);
        foreach (q[j]) apply_op(q[j]);
        #2 rst_n = 1'b0;
        #1 model_reset();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (obs(i) !== expw(i)) begin
                n_err++;
                $display("FAIL async_reset dut%0d: got %h want %h", i, obs(i), expw(i));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q.delete();
        q.push_back('{OP_START, 0});
        add_periods(q, 3);
        foreach (q[j]) begin
            apply_op(q[j]);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs(i) !== expw(i)) begin
                    n_err++;
                    $display("FAIL after_reset op%0d dut%0d: got %h want %h", j, i, obs(i), expw(i));
                end
            end
        end
    endtask

    task automatic test_random();
        op_t o;
        int  r;
        hard_reset();
        for (int j = 0; j < 300; j++) begin
            r = int'($urandom_range(0, 15));
            case (r)
                0, 1:    o = '{OP_START, 0};
                2:       o = '{OP_STOP, 0};
                3:       o = '{OP_BOTH, 0};
                4, 5:    o = '{OP_TGT, int'($urandom_range(0, 255))};
                6:       o = '{OP_TGT, ($urandom_range(0, 1) != 0) ? 255 : 0};
                7:       o = '{OP_DWELL, int'($urandom_range(0, 3))};
                default: o = '{OP_PER, 0};
            endcase
            apply_op(o);
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (obs(i) !== expw(i)) begin
                    n_err++;
                    $display("FAIL random op%0d kind%0d dut%0d: got %h want %h", j, o.k, i, obs(i), expw(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_saturate();
        test_dwell();
        test_retarget();
        test_stop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
